// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op encoding, FSM states and the accepted multi-cycle op set.
// MDU_MADD_EN adds MADD/MSUB to the multi-cycle op set.
package mdu_pkg;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;
  function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};
`else
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide/accumulate datapath producing {HI,LO}.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);
  logic [63:0] sprod, uprod, acc_p, acc_m;
  logic [31:0] num, den, den_nz, uq, ur, q, r;
  logic        sgn;
  assign sprod  = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign uprod  = {32'b0, rs_i} * {32'b0, rt_i};
  assign acc_p  = {hi_i, lo_i} + sprod;
  assign acc_m  = {hi_i, lo_i} - sprod;
  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign sgn    = op_i == OP_DIV;
  assign num    = (sgn & rs_i[31]) ? -rs_i : rs_i;
  assign den    = (sgn & rt_i[31]) ? -rt_i : rt_i;
  assign den_nz = (den == 32'd0) ? 32'd1 : den;
  assign uq     = num / den_nz;
  assign ur     = num % den_nz;
  assign q      = (sgn & (rs_i[31] ^ rt_i[31])) ? -uq : uq;
  assign r      = (sgn & rs_i[31]) ? -ur : ur;
  always_comb begin
    {res_hi_o, res_lo_o} = 64'd0;
    {res_hi_o, res_lo_o} = (op_i == OP_MULT)  ? sprod :
                           (op_i == OP_MULTU) ? uprod :
                           (op_i == OP_DIV || op_i == OP_DIVU) ?
                             ((rt_i == 32'd0) ? {rs_i, 32'hFFFF_FFFF} : {r, q}) :
                           (op_i == OP_MADD)  ? acc_p :
                           (op_i == OP_MSUB)  ? acc_m : 64'd0;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MDU sequencer owning HI/LO, multi-cycle latency and D-stage stall.
// MDU_MADD_EN enables MADD/MSUB accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_mdu_class,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_e      state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi, res_lo;
  logic        idle, launch, commit, is_div;
  mdu_arith u_arith (
    .op_i     (op),
    .rs_i     (rs_val),
    .rt_i     (rt_val),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );
  assign idle   = state_q == S_IDLE;
  assign launch = start & idle & is_long_op(op);
  assign commit = !idle && count_q == CW'(1);
  assign is_div = op == OP_DIV || op == OP_DIVU;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
    assert (reset || !(start && state_q == S_BUSY)) else $error("mdu_ctrl: start while busy");
  end
  always_comb begin
    state_d   = launch ? S_BUSY : commit ? S_IDLE : state_q;
    count_d   = launch ? (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                idle   ? count_q : count_q - 1'b1;
    pend_hi_d = launch ? res_hi : pend_hi_q;
    pend_lo_d = launch ? res_lo : pend_lo_q;
    hi_d      = commit ? pend_hi_q : (start & idle & op == OP_MTHI) ? rs_val : hi_q;
    lo_d      = commit ? pend_lo_q : (start & idle & op == OP_MTLO) ? rs_val : lo_q;
  end
  // Stall also covers the issuing cycle so a trailing mfhi/mflo never sees stale HI/LO.
  always_comb begin
    busy  = state_q == S_BUSY;
    stall = ~reset & d_mdu_class & (busy | start);
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized checks of mdu_ctrl against a 64-bit arithmetic model.
module tb_mdu_ctrl;
  import mdu_pkg::*;
  localparam int MC = 5, DC = 10;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, d_mdu_class = 1'b0;
  logic [3:0] op = OP_NONE;
  logic [31:0] rs_val = '0, rt_val = '0, hi, lo;
  logic busy, stall;
  logic [31:0] m_hi = '0, m_lo = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .d_mdu_class(d_mdu_class), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic bit madd_en();
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int latency(input logic [3:0] o);
    if (o == OP_MULT || o == OP_MULTU) return MC;
    if (o == OP_DIV || o == OP_DIVU) return DC;
    if ((o == OP_MADD || o == OP_MSUB) && madd_en()) return MC;
    return 0;
  endfunction
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, b, h, l);
    longint sa = longint'($signed(a)), sb = longint'($signed(b)), q, r;
    longint unsigned ua = {32'b0, a}, ub = {32'b0, b}, uq, ur;
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      OP_MADD:  return madd_en() ? {h, l} + sa * sb : {h, l};
      OP_MSUB:  return madd_en() ? {h, l} - sa * sb : {h, l};
      OP_MTHI:  return {a, l};
      OP_MTLO:  return {h, a};
      default:  return {h, l};
    endcase
  endfunction
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic dmc);
    int n = latency(o);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_mdu_class = dmc;
    #1 chk("stall_issue", stall, dmc);
    e = model(o, a, b, m_hi, m_lo);
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    for (int i = 0; i < n; i++) begin
      chk("busy", busy, 1);
      chk("stall_busy", stall, dmc);
      chk("hold", {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
    end
    {m_hi, m_lo} = e;
    chk("busy_done", busy, 0);
    chk("hilo", {hi, lo}, e);
    d_mdu_class = 1'b0;
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    start = 1'b1; op = OP_MULT; d_mdu_class = 1'b1;
    #1 chk("stall_in_reset", stall, 0);
    chk("reset_busy", busy, 0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    start = 1'b0; d_mdu_class = 1'b0; reset = 1'b0;
    run(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("t1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run(OP_DIVU, 32'd7, 32'd2, 1'b0);
    chk("t2_divu", {hi, lo}, {32'd1, 32'd3});
    run(OP_DIV, -32'sd7, 32'd2, 1'b0);
    chk("t2_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(OP_DIV, 32'd5, 32'd0, 1'b0);
    chk("t3_div0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("t3_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    run(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    d_mdu_class = 1'b1;
    #1 chk("t4_no_stall_idle", stall, 0);
    d_mdu_class = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (2) @(negedge clk);
    chk("t5_busy3", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_hilo", {hi, lo}, 64'd0);
    repeat (MC + 2) @(negedge clk);
    chk("t5_no_commit", {hi, lo}, 64'd0);
    run(OP_MTLO, 32'h1234, 32'd0, 1'b0);
    chk("t5_mtlo", lo, 32'h1234);
    run(4'hF, 32'd1, 32'd1, 1'b0);
    run(OP_NONE, 32'd1, 32'd1, 1'b0);
    run(OP_MTHI, 32'd0, 32'd0, 1'b0);
    run(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(OP_MADD, 32'd1, 32'd1, 1'b0);
    chk("t6_madd", {hi, lo}, madd_en() ? {32'd1, 32'd0} : {32'd0, 32'hFFFF_FFFF});
    for (int k = 0; k < 40; k++)
      run(4'($urandom_range(0, 9)), pick(), pick(), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
